// File: rtl/sum_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package sum_pkg;

    localparam int SUM_WIDTH_DEFAULT = 4;

    function automatic int sum_width(input int width);
        return width + 1;
    endfunction

    typedef logic [SUM_WIDTH_DEFAULT-1:0] operand_t;
    typedef logic [SUM_WIDTH_DEFAULT:0]   sum_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One ripple stage: sum and majority carry of two operand bits plus carry-in.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sum_4bit.sv
// Unsigned adder with a one-cycle registered result; the carry-out is the result MSB.
module sum_4bit
    import sum_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            x0,
    input  logic [WIDTH-1:0]            x1,
    input  logic                        in_valid,
    output logic [sum_width(WIDTH)-1:0] o,
    output logic                        out_valid
);

    logic [WIDTH:0]                w_carry;
    logic [WIDTH-1:0]              w_s;
    logic [sum_width(WIDTH)-1:0]   w_sum;
    logic [sum_width(WIDTH)-1:0]   r_o;
    logic                          r_valid;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder_1bit u_fa (
            .a    (x0[i]),
            .b    (x1[i]),
            .cin  (w_carry[i]),
            .s    (w_s[i]),
            .cout (w_carry[i+1])
        );
    end

    assign w_sum = {w_carry[WIDTH], w_s};

    // Result and valid registers; o follows the sum every cycle, consumers qualify it with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_o     <= w_sum;
            r_valid <= in_valid;
        end
    end

    assign o         = r_o;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_sum_4bit.sv
// Directed bench for sum_4bit: arithmetic reference model plus hand-computed literal checks.
module tb_sum_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] x0 = 4'd0;
    logic [3:0] x1 = 4'd0;
    logic       in_valid = 1'b0;
    logic [4:0] o;
    logic       out_valid;

    int n_checks = 0;
    int n_fails  = 0;
    bit check_en = 1'b0;

    // Reference: result of the pair seen at the last rising edge, cleared by reset.
    int m_o = 0;
    int m_v = 0;

    sum_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .x0        (x0),
        .x1        (x1),
        .in_valid  (in_valid),
        .o         (o),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_o <= 0;
            m_v <= 0;
        end else begin
            m_o <= int'(x0) + int'(x1);
            m_v <= int'(in_valid);
        end
    end

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_o", int'(o), m_o);
            chk("model_valid", int'(out_valid), m_v);
        end
    end

    task automatic drive(input int a, input int b, input bit v);
        @(negedge clk);
        x0 = 4'(a);
        x1 = 4'(b);
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int eo, input int ev);
        chk({name, "_o"}, int'(o), eo);
        chk({name, "_valid"}, int'(out_valid), ev);
        chk({name, "_model"}, m_o, eo);
    endtask

    initial begin
        x0 = 4'd9;
        x1 = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("reset_hold_o", int'(o), 0);
            chk("reset_hold_valid", int'(out_valid), 0);
        end

        @(negedge clk);
        #2;
        rst = 1'b0;
        drive(3, 4, 1'b1);   expect_out("basic_3p4", 7, 1);
        drive(15, 15, 1'b1); expect_out("carry_15p15", 30, 1);
        drive(8, 8, 1'b1);   expect_out("carry_8p8", 16, 1);
        drive(15, 1, 1'b1);  expect_out("carry_15p1", 16, 1);

        drive(1, 2, 1'b1);   expect_out("gate_1p2", 3, 1);
        drive(6, 6, 1'b0);   expect_out("gate_6p6", 12, 0);
        drive(9, 9, 1'b1);   expect_out("gate_9p9", 18, 1);

        // Asynchronous reset in the high phase, well before the next edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_o", int'(o), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                @(negedge clk);
                #2;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                chk("midrst_held_valid", int'(out_valid), 0);
                @(negedge clk);
                #2;
                rst = 1'b0;
                x0 = 4'd2;
                x1 = 4'd2;
                in_valid = 1'b1;
                #1;
                chk("midrst_pre_edge_valid", int'(out_valid), 0);
                chk("midrst_pre_edge_o", int'(o), 0);
                @(posedge clk);
                #1;
                expect_out("midrst_2p2", 4, 1);
            end
            drive(i / 16, i % 16, 1'b1);
            chk("sweep_o", int'(o), (i / 16) + (i % 16));
            chk("sweep_valid", int'(out_valid), 1);
            if (i == 14 * 16 + 14) expect_out("sweep_14p14", 28, 1);
            if (i == 0)            expect_out("sweep_0p0", 0, 1);
            if (i == 5 * 16 + 10)  expect_out("sweep_5p10", 15, 1);
        end

        drive(0, 0, 1'b0);
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
